// File: rtl/shot_pkg.sv
// Shared types and widths for the shot pool: direction encoding, slot state, fixed-point sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shot_pkg;

    // Integer pixel width of every on-screen coordinate.
    localparam int POS_INT_W = 11;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic {
        SLOT_IDLE   = 1'b0,
        SLOT_FLYING = 1'b1
    } slot_state_t;

    // Signed fixed-point width: sign bit + integer pixel bits + fraction bits.
    function automatic int fx_width(input int frac_bits);
        return POS_INT_W + frac_bits + 1;
    endfunction

endpackage

// File: rtl/shot_channel.sv
// One projectile slot: IDLE/FLYING state, fixed-point position and speed, bounds kill, optional lifetime.
// Latency: spawn/kill/move take effect on the clock edge after the request cycle.
// Backpressure: none; the parent only spawns into an idle slot, collision strobes on an idle slot are ignored.
// Ports: clk/reset, i_sof frame pulse, i_spawn + i_dir + i_spawn_x/y load request, i_collision hit strobe,
//        o_alive slot flying flag, o_x/o_y integer pixel position.
// Optional feature: SHOT_LIFETIME_EN adds a per-slot frame countdown that auto-kills the shot.
module shot_channel
    import shot_pkg::*;
#(
    parameter int FRAC_BITS  = 6,
    parameter int SHOT_SPEED = 200,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479
`ifdef SHOT_LIFETIME_EN
    ,
    parameter int LIFETIME_FRAMES = 60
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_sof,
    input  logic                 i_spawn,
    input  logic [1:0]           i_dir,
    input  logic [POS_INT_W-1:0] i_spawn_x,
    input  logic [POS_INT_W-1:0] i_spawn_y,
    input  logic                 i_collision,
    output logic                 o_alive,
    output logic [POS_INT_W-1:0] o_x,
    output logic [POS_INT_W-1:0] o_y
);

    localparam int W = fx_width(FRAC_BITS);
    localparam logic signed [W-1:0]       SPEED = W'(SHOT_SPEED);
    localparam logic [POS_INT_W-1:0]      X_LIM = POS_INT_W'(X_MAX);
    localparam logic [POS_INT_W-1:0]      Y_LIM = POS_INT_W'(Y_MAX);

    slot_state_t         r_state;
    slot_state_t         w_state_nxt;
    dir_t                w_dir;
    logic signed [W-1:0] r_pos_x, r_pos_y, r_spd_x, r_spd_y;
    logic signed [W-1:0] w_spd_x, w_spd_y, w_nxt_x, w_nxt_y;
    logic                w_oob, w_expire, w_move;

    assign w_dir   = dir_t'(i_dir);
    assign w_nxt_x = r_pos_x + r_spd_x;
    assign w_nxt_y = r_pos_y + r_spd_y;

    // Candidate position leaves the screen if it goes negative or its pixel part exceeds the last legal pixel.
    assign w_oob = w_nxt_x[W-1] | w_nxt_y[W-1]
                 | (w_nxt_x[FRAC_BITS +: POS_INT_W] > X_LIM)
                 | (w_nxt_y[FRAC_BITS +: POS_INT_W] > Y_LIM);

`ifdef SHOT_LIFETIME_EN
    localparam int LW = (LIFETIME_FRAMES < 2) ? 1 : $clog2(LIFETIME_FRAMES + 1);
    logic [LW-1:0] r_life;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_life <= '0;
        end else if (i_spawn) begin
            r_life <= LW'(LIFETIME_FRAMES);
        end else if (r_state == SLOT_FLYING && i_sof && r_life != '0) begin
            r_life <= r_life - 1'b1;
        end
    end

    // The frame that takes the counter to zero is the frame the shot dies on.
    assign w_expire = (r_life <= LW'(1));
`else
    assign w_expire = 1'b0;
`endif

    // Collision beats a same-cycle move; bounds and lifetime kills leave the position untouched.
    assign w_move = (r_state == SLOT_FLYING) & i_sof & ~i_collision & ~w_oob & ~w_expire;

    always_comb begin
        w_spd_x = '0;
        w_spd_y = '0;
        case (w_dir)
            DIR_UP:    w_spd_y = -SPEED;
            DIR_RIGHT: w_spd_x = SPEED;
            DIR_DOWN:  w_spd_y = SPEED;
            DIR_LEFT:  w_spd_x = -SPEED;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SLOT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_IDLE:   if (i_spawn) w_state_nxt = SLOT_FLYING;
            SLOT_FLYING: if (i_collision || (i_sof && (w_oob || w_expire))) w_state_nxt = SLOT_IDLE;
            default:     w_state_nxt = SLOT_IDLE;
        endcase
    end

    always_comb begin
        o_alive = (r_state == SLOT_FLYING);
        o_x     = r_pos_x[FRAC_BITS +: POS_INT_W];
        o_y     = r_pos_y[FRAC_BITS +: POS_INT_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_spd_x <= '0;
            r_spd_y <= '0;
        end else if (i_spawn) begin
            r_pos_x <= {1'b0, i_spawn_x, {FRAC_BITS{1'b0}}};
            r_pos_y <= {1'b0, i_spawn_y, {FRAC_BITS{1'b0}}};
            r_spd_x <= w_spd_x;
            r_spd_y <= w_spd_y;
        end else if (w_move) begin
            r_pos_x <= w_nxt_x;
            r_pos_y <= w_nxt_y;
        end
    end

endmodule

// File: rtl/shot_pool_ctrl.sv
// Multi-slot projectile manager: allocates the lowest idle slot on fire, enforces a frame cooldown, packs slot outputs.
// Latency: spawn visible (alive/position/shot_fired) one cycle after the qualifying fire cycle.
// Backpressure: fire requests while the pool is full, cooling down or player asleep are dropped silently.
// Ports: clk/reset, startOfFrame pulse, fire_pressed/player_awake/player_direction/playerX/YPosition from the
//        player, fireCollision per slot; alive, packed topLeftX/topLeftY (slot i at [i*11 +: 11]), shot_fired, pool_full.
// Optional feature: SHOT_LIFETIME_EN enables per-slot auto-kill after LIFETIME_FRAMES frames.
module shot_pool_ctrl
    import shot_pkg::*;
#(
    parameter int NUM_SHOTS       = 4,
    parameter int FRAC_BITS       = 6,
    parameter int SHOT_SPEED      = 200,
    parameter int SPAWN_OFFSET    = 16,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479
`ifdef SHOT_LIFETIME_EN
    ,
    parameter int LIFETIME_FRAMES = 60
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   fire_pressed,
    input  logic                   player_awake,
    input  logic [1:0]             player_direction,
    input  logic [10:0]            playerXPosition,
    input  logic [10:0]            playerYPosition,
    input  logic [NUM_SHOTS-1:0]   fireCollision,
    output logic [NUM_SHOTS-1:0]   alive,
    output logic [NUM_SHOTS*11-1:0] topLeftX,
    output logic [NUM_SHOTS*11-1:0] topLeftY,
    output logic                   shot_fired,
    output logic                   pool_full
);

    localparam int CW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

    logic [CW-1:0]          r_cooldown;
    logic                   r_shot_fired;
    logic                   w_spawn;
    logic [NUM_SHOTS-1:0]   w_free, w_pick, w_spawn_vec;
    logic [POS_INT_W-1:0]   w_spawn_x, w_spawn_y;

    assign pool_full  = &alive;
    assign shot_fired = r_shot_fired;

    // Lowest set bit of the idle mask; alive is registered, so a slot killed this edge is only offered next cycle.
    assign w_free      = ~alive;
    assign w_pick      = w_free & (~w_free + NUM_SHOTS'(1));
    assign w_spawn     = fire_pressed & player_awake & (r_cooldown == '0) & ~pool_full;
    assign w_spawn_vec = w_pick & {NUM_SHOTS{w_spawn}};

    assign w_spawn_x = playerXPosition + POS_INT_W'(SPAWN_OFFSET);
    assign w_spawn_y = playerYPosition + POS_INT_W'(SPAWN_OFFSET);

    // A spawn reload wins over the frame decrement in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cooldown   <= '0;
            r_shot_fired <= 1'b0;
        end else begin
            r_shot_fired <= w_spawn;
            if (w_spawn) begin
                r_cooldown <= CW'(COOLDOWN_FRAMES);
            end else if (startOfFrame && r_cooldown != '0) begin
                r_cooldown <= r_cooldown - 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
        shot_channel #(
            .FRAC_BITS      (FRAC_BITS),
            .SHOT_SPEED     (SHOT_SPEED),
            .X_MAX          (X_MAX),
            .Y_MAX          (Y_MAX)
`ifdef SHOT_LIFETIME_EN
            ,
            .LIFETIME_FRAMES(LIFETIME_FRAMES)
`endif
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .i_sof      (startOfFrame),
            .i_spawn    (w_spawn_vec[g]),
            .i_dir      (player_direction),
            .i_spawn_x  (w_spawn_x),
            .i_spawn_y  (w_spawn_y),
            .i_collision(fireCollision[g]),
            .o_alive    (alive[g]),
            .o_x        (topLeftX[g*POS_INT_W +: POS_INT_W]),
            .o_y        (topLeftY[g*POS_INT_W +: POS_INT_W])
        );
    end

endmodule

// File: tb/tb_shot_pool_ctrl.sv
module tb_shot_pool_ctrl;

    localparam int NS   = 4;
    localparam int FB   = 6;
    localparam int SPD  = 200;
    localparam int OFS  = 16;
    localparam int COOL = 8;
    localparam int XM   = 639;
    localparam int YM   = 479;
`ifdef SHOT_LIFETIME_EN
    localparam int LIFE = 3;
`else
    localparam int LIFE = 0;   // 0: shots never expire
`endif

    logic              clk = 1'b0;
    logic              reset, sof, fire, awake;
    logic [1:0]        dir;
    logic [10:0]       pxp, pyp;
    logic [NS-1:0]     col, alive;
    logic [NS*11-1:0]  tlx, tly;
    logic              fired, full;

    always #5 clk = ~clk;

    shot_pool_ctrl #(
        .NUM_SHOTS(NS), .FRAC_BITS(FB), .SHOT_SPEED(SPD), .SPAWN_OFFSET(OFS),
        .COOLDOWN_FRAMES(COOL), .X_MAX(XM), .Y_MAX(YM)
`ifdef SHOT_LIFETIME_EN
        , .LIFETIME_FRAMES(LIFE)
`endif
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(sof), .fire_pressed(fire), .player_awake(awake),
        .player_direction(dir), .playerXPosition(pxp), .playerYPosition(pyp), .fireCollision(col),
        .alive(alive), .topLeftX(tlx), .topLeftY(tly), .shot_fired(fired), .pool_full(full)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: whole-pixel-times-64 integers, updated per clock from the behavioural rules.
    bit m_alive[NS];
    int m_px[NS], m_py[NS], m_vx[NS], m_vy[NS], m_life[NS];
    int m_cd;
    bit m_fired;

    task automatic model_step();
        int tgt, nx, ny;
        bit spawn;
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                m_alive[i] = 0; m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_life[i] = 0;
            end
            m_cd = 0;
            m_fired = 0;
            return;
        end
        tgt = -1;
        for (int i = NS - 1; i >= 0; i--) if (!m_alive[i]) tgt = i;
        spawn = fire && awake && (m_cd == 0) && (tgt >= 0);
        for (int i = 0; i < NS; i++) begin
            if (m_alive[i]) begin
                if (col[i]) begin
                    m_alive[i] = 0;
                end else if (sof) begin
                    nx = m_px[i] + m_vx[i];
                    ny = m_py[i] + m_vy[i];
                    if (LIFE > 0) m_life[i]--;
                    if (nx < 0 || ny < 0 || (nx >>> FB) > XM || (ny >>> FB) > YM ||
                        (LIFE > 0 && m_life[i] <= 0))
                        m_alive[i] = 0;
                    else begin
                        m_px[i] = nx;
                        m_py[i] = ny;
                    end
                end
            end
        end
        if (spawn) begin
            m_alive[tgt] = 1;
            m_px[tgt] = ((int'(pxp) + OFS) & 2047) << FB;
            m_py[tgt] = ((int'(pyp) + OFS) & 2047) << FB;
            m_vx[tgt] = (dir == 2'd1) ? SPD : (dir == 2'd3) ? -SPD : 0;
            m_vy[tgt] = (dir == 2'd2) ? SPD : (dir == 2'd0) ? -SPD : 0;
            m_life[tgt] = LIFE;
        end
        if (spawn) m_cd = COOL;
        else if (sof && m_cd > 0) m_cd--;
        m_fired = spawn;
    endtask

    task automatic compare_all();
        bit all_alive;
        all_alive = 1;
        for (int i = 0; i < NS; i++) begin
            check($sformatf("model_alive[%0d]", i), alive[i], m_alive[i]);
            check($sformatf("model_x[%0d]", i), tlx[i*11 +: 11], (m_px[i] >>> FB) & 2047);
            check($sformatf("model_y[%0d]", i), tly[i*11 +: 11], (m_py[i] >>> FB) & 2047);
            all_alive &= m_alive[i];
        end
        check("model_shot_fired", fired, m_fired);
        check("model_pool_full", full, all_alive);
    endtask

    // Inputs are set between ticks; model and DUT see the same values at the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic frame();
        sof = 1'b1; tick();
        sof = 1'b0; tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; sof = 1'b0; fire = 1'b0; col = '0;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] dir;
        int px, py, nframes;
        bit exp_alive;
        int exp_x, exp_y;
    } vec_t;

    vec_t tab[12];
    int   seen, last_sp, n_sp;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0]  = '{2'd1, 100, 100, 0, 1'b1, 116, 116};
        tab[1]  = '{2'd1, 100, 100, 2, 1'b1, 122, 116};
        tab[2]  = '{2'd0, 100, 100, 1, 1'b1, 116, 112};
        tab[3]  = '{2'd2, 100, 100, 1, 1'b1, 116, 119};
        tab[4]  = '{2'd3, 100, 100, 1, 1'b1, 112, 116};
        tab[5]  = '{2'd1, 620, 100, 1, 1'b1, 639, 116};
        tab[6]  = '{2'd1, 620, 100, 2, 1'b0, 639, 116};
        tab[7]  = '{2'd2, 100, 460, 1, 1'b1, 116, 479};
        tab[8]  = '{2'd2, 100, 460, 2, 1'b0, 116, 479};
        tab[9]  = '{2'd3,   0, 100, 5, 1'b1,   0, 116};
        tab[10] = '{2'd3,   0, 100, 6, 1'b0,   0, 116};
        tab[11] = '{2'd0, 100,   0, 6, 1'b0, 116,   0};

        awake = 1'b1; dir = 2'd0; pxp = '0; pyp = '0;
        do_reset();
        tick();

        // Idle after reset: nothing spawns or moves.
        seen = 0;
        for (int f = 0; f < 6; f++) begin
            sof = (f % 2 == 0);
            tick();
            if (fired) seen++;
        end
        sof = 1'b0;
        check("idle_shot_fired_count", seen, 0);
        check("idle_alive", alive, 0);
        check("idle_topLeftX", tlx, 0);
        check("idle_topLeftY", tly, 0);

        // Spawn position, direction and screen-edge vectors on slot 0.
        foreach (tab[k]) begin
            if (LIFE == 0 || tab[k].nframes < LIFE) begin
                do_reset();
                pxp = 11'(tab[k].px); pyp = 11'(tab[k].py); dir = tab[k].dir;
                fire = 1'b1; tick(); fire = 1'b0;
                repeat (tab[k].nframes) frame();
                check($sformatf("vec%0d_alive", k), alive[0], tab[k].exp_alive);
                check($sformatf("vec%0d_x", k), tlx[10:0], tab[k].exp_x);
                check($sformatf("vec%0d_y", k), tly[10:0], tab[k].exp_y);
            end
        end

        // Fire held: spawns spaced by the cooldown; pool fills and further requests drop.
        do_reset();
        pxp = 11'd100; pyp = 11'd100; dir = 2'd1; fire = 1'b1;
        last_sp = -1; n_sp = 0;
        for (int c = 1; c <= 200; c++) begin
            sof = (c % 4 == 0);
            tick();
            if (fired) begin
                if (last_sp >= 0) check("cooldown_interval", c - last_sp, COOL * 4);
                last_sp = c;
                n_sp++;
            end
        end
        sof = 1'b0; fire = 1'b0;
`ifndef SHOT_LIFETIME_EN
        check("pool_spawn_count", n_sp, NS);
        check("pool_full_flag", full, 1);
        check("pool_alive", alive, {NS{1'b1}});
`endif

`ifndef SHOT_LIFETIME_EN
        // Collision on a moving slot, and a spawn that coincides with a strobe on its dead target slot.
        do_reset();
        pxp = 11'd100; pyp = 11'd100; dir = 2'd1;
        fire = 1'b1; tick(); fire = 1'b0;
        repeat (8) frame();
        dir = 2'd0; fire = 1'b1; tick(); fire = 1'b0;
        check("col_spawn_alive1", alive[1], 1);
        check("col_spawn_y1", tly[21:11], 116);
        col = 4'b0010; sof = 1'b1; tick(); col = '0; sof = 1'b0;
        check("col_kill_alive1", alive[1], 0);
        check("col_kill_y1_held", tly[21:11], 116);
        check("col_slot0_moved_x", tlx[10:0], 144);
        repeat (8) frame();
        dir = 2'd2; fire = 1'b1; col = 4'b0010; tick(); fire = 1'b0; col = '0;
        check("spawn_beats_col_alive1", alive[1], 1);
        check("spawn_beats_col_y1", tly[21:11], 116);
`endif

        // Lifetime: shot dies on the third frame only when the feature is built in.
        do_reset();
        pxp = 11'd100; pyp = 11'd100; dir = 2'd1;
        fire = 1'b1; tick(); fire = 1'b0;
        frame(); frame();
        check("life_alive_2_frames", alive[0], 1);
        frame();
`ifdef SHOT_LIFETIME_EN
        check("life_dead_3_frames", alive[0], 0);
`else
        check("life_alive_3_frames", alive[0], 1);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            sof   = ($urandom_range(0, 3) == 0);
            fire  = ($urandom_range(0, 9) < 4);
            awake = ($urandom_range(0, 9) < 8);
            dir   = 2'($urandom_range(0, 3));
            pxp   = 11'($urandom_range(0, 700));
            pyp   = 11'($urandom_range(0, 520));
            for (int i = 0; i < NS; i++) col[i] = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; sof = 1'b0; fire = 1'b0; col = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
